// File: rtl/filt_job_sequencer.sv
// Job sequencer: latches a job, streams read addresses and LAT-delayed write addresses.
// Latency: first rd_en the cycle after start, wr_en LAT cycles after each rd_en, done one cycle after last wr_en.
// Backpressure: pause gates new reads that same cycle, words already issued keep flowing. FILT_SEQ_PERF_EN adds perf counters.
module filt_job_sequencer #(
  parameter int AW  = 32,
  parameter int LAT = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] filesize,
  input  logic [AW-1:0] src_base,
  input  logic [AW-1:0] dst_base,
  input  logic          pause,
  output logic          busy,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          done
`ifdef FILT_SEQ_PERF_EN
  ,
  output logic [AW-1:0] stall_cnt,
  output logic [AW-1:0] job_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [AW-1:0] ONE = AW'(1);

  state_t        state;
  logic [AW-1:0] fs_q;
  logic [AW-1:0] src_q;
  logic [AW-1:0] dst_q;
  logic [AW-1:0] rd_cnt;
  logic [AW-1:0] wr_cnt;
  logic [AW-1:0] rd_last;
  logic [AW-1:0] wr_last;
  logic [LAT-1:0] vld_sr;
  logic          rd_more;
  logic          accept;

  assign accept  = (state == IDLE) && start;
  assign rd_more = rd_cnt < fs_q;
  assign rd_en   = (state == RUN) && !pause && rd_more;
  assign wr_en   = vld_sr[LAT-1];
  // Addresses show the live sum while strobed, otherwise the last issued value.
  assign rd_addr = rd_en ? (src_q + rd_cnt) : rd_last;
  assign wr_addr = wr_en ? (dst_q + wr_cnt) : wr_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      fs_q    <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      rd_last <= '0;
      wr_last <= '0;
      vld_sr  <= '0;
    end else begin
      vld_sr <= (vld_sr << 1) | LAT'(rd_en);
      done   <= 1'b0;
      if (rd_en) begin
        rd_cnt  <= rd_cnt + ONE;
        rd_last <= rd_addr;
      end
      if (wr_en) begin
        wr_cnt  <= wr_cnt + ONE;
        wr_last <= wr_addr;
      end
      case (state)
        IDLE: begin
          if (start) begin
            fs_q   <= filesize;
            src_q  <= src_base;
            dst_q  <= dst_base;
            rd_cnt <= '0;
            wr_cnt <= '0;
            busy   <= 1'b1;
            if (filesize == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (rd_en && (rd_cnt == fs_q - ONE)) state <= DRAIN;
        end
        DRAIN: begin
          if (wr_en && (wr_cnt == fs_q - ONE)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FILT_SEQ_PERF_EN
  // job_cycles restarts at 1 so the accepting cycle itself is counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt  <= '0;
      job_cycles <= '0;
    end else if (accept) begin
      stall_cnt  <= '0;
      job_cycles <= ONE;
    end else begin
      if ((state == RUN) && pause && rd_more && (stall_cnt != '1))
        stall_cnt <= stall_cnt + ONE;
      if ((state != IDLE) && (job_cycles != '1))
        job_cycles <= job_cycles + ONE;
    end
  end
`endif

endmodule

// File: tb/tb_filt_job_sequencer.sv
// Directed bench for filt_job_sequencer with address scoreboards on the read and write streams.
module tb_filt_job_sequencer;
  localparam int LAT = 3;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] filesize;
  logic [31:0] src_base;
  logic [31:0] dst_base;
  logic        pause;
  logic        busy;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic        done;
`ifdef FILT_SEQ_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] job_cycles;
`endif

  filt_job_sequencer #(.AW(32), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .filesize(filesize),
    .src_base(src_base), .dst_base(dst_base), .pause(pause), .busy(busy),
    .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en), .wr_addr(wr_addr), .done(done)
`ifdef FILT_SEQ_PERF_EN
    , .stall_cnt(stall_cnt), .job_cycles(job_cycles)
`endif
  );

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  logic [31:0] rd_q[$];
  logic [31:0] wr_q[$];
  int rd_n, wr_n, first_rd, first_wr, last_wr;
  logic [LAT-1:0] hist = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops scoreboard entries and checks the rd->wr delay.
  always @(negedge clk) begin
    if (rd_en) begin
      rd_n++;
      if (first_rd < 0) first_rd = cyc;
      check("rd_during_pause", {31'd0, pause}, 32'd0);
      if (rd_q.size() == 0) check("rd_unexpected", {31'd0, rd_en}, 32'd0);
      else check("rd_addr", rd_addr, rd_q.pop_front());
    end
    if (wr_en) begin
      wr_n++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      if (wr_q.size() == 0) check("wr_unexpected", {31'd0, wr_en}, 32'd0);
      else check("wr_addr", wr_addr, wr_q.pop_front());
    end
    check("wr_lat", {31'd0, wr_en}, {31'd0, hist[LAT-1]});
    hist = reset ? '0 : ((hist << 1) | LAT'(rd_en));
  end

  task automatic do_job(input logic [31:0] fs, input logic [31:0] src, input logic [31:0] dst,
                        input logic [15:0] pmask, input int again_k, input bit start_at_done,
                        input int exp_len);
    int s, k, d;
    bit got;
    rd_n = 0; wr_n = 0; first_rd = -1; first_wr = -1; last_wr = -1;
    for (int i = 0; i < int'(fs); i++) begin
      rd_q.push_back(src + i);
      wr_q.push_back(dst + i);
    end
    @(posedge clk); #1;
    start = 1'b1; filesize = fs; src_base = src; dst_base = dst; pause = 1'b0;
    s = cyc;
    @(negedge clk);
    check("busy_at_start", {31'd0, busy}, 32'd0);
    got = 1'b0; d = 0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(posedge clk); #1;
      k = cyc - s - 1;
      start = 1'b0;
      filesize = $urandom; src_base = $urandom; dst_base = $urandom;
      if (k == again_k) start = 1'b1;
      if (start_at_done && cyc == s + exp_len - 1) begin
        start = 1'b1;
        filesize = 32'd0;
      end
      pause = (k < 16) ? pmask[k] : 1'b0;
      @(negedge clk);
      check("busy_in_job", {31'd0, busy}, 32'd1);
      if (done) begin
        got = 1'b1;
        d = cyc;
      end
    end
    check("done_seen", {31'd0, got}, 32'd1);
    check("job_len", d - s + 1, exp_len);
    @(posedge clk); #1;
    if (!start_at_done) start = 1'b0;
    pause = 1'b0;
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("rd_count", rd_n, fs);
    check("wr_count", wr_n, fs);
    check("rd_q_empty", rd_q.size(), 32'd0);
    check("wr_q_empty", wr_q.size(), 32'd0);
    if (fs != 0) begin
      check("first_rd", first_rd, s + 1);
      check("wr_lag", first_wr - first_rd, LAT);
      check("done_after_wr", d, last_wr + 1);
    end
`ifdef FILT_SEQ_PERF_EN
    check("job_cycles", job_cycles, exp_len);
`endif
  endtask

  initial begin
    int s;
    reset = 1'b1; start = 1'b0; filesize = '0; src_base = '0; dst_base = '0; pause = 1'b0;
    rd_n = 0; wr_n = 0; first_rd = -1; first_wr = -1; last_wr = -1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rd_en", {31'd0, rd_en}, 32'd0);
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_rd_addr", rd_addr, 32'd0);
    check("rst_wr_addr", wr_addr, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Full-rate job; a start raised in the done cycle must wait for IDLE.
    do_job(32'd8, 32'h100, 32'h800, 16'h0, -1, 1'b1, 13);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("late_start_busy", {31'd0, busy}, 32'd1);
    check("late_start_done", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("late_start_idle", {31'd0, busy}, 32'd0);

    do_job(32'd6, 32'h40, 32'h2000, 16'b0110, -1, 1'b0, 13);
`ifdef FILT_SEQ_PERF_EN
    check("stall_cnt", stall_cnt, 32'd2);
`endif
    do_job(32'd0, 32'h10, 32'h20, 16'h0, -1, 1'b0, 2);
    do_job(32'd4, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 16'h0, -1, 1'b0, 9);
    do_job(32'd5, 32'h400, 32'hC00, 16'h0, 2, 1'b0, 10);

    // Reset in DRAIN with two words still in the pipeline.
    for (int i = 0; i < 4; i++) rd_q.push_back(32'h200 + i);
    wr_q.push_back(32'h900);
    wr_q.push_back(32'h901);
    @(posedge clk); #1;
    start = 1'b1; filesize = 32'd4; src_base = 32'h200; dst_base = 32'h900;
    s = cyc;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("drain_cycle", cyc, s + 5);
    check("drain_busy", {31'd0, busy}, 32'd1);
    check("drain_wr_en", {31'd0, wr_en}, 32'd1);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_rd_en", {31'd0, rd_en}, 32'd0);
    check("abort_wr_en", {31'd0, wr_en}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_rd_addr", rd_addr, 32'd0);
    check("abort_wr_addr", wr_addr, 32'd0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("abort_rd_q", rd_q.size(), 32'd0);
    check("abort_wr_q", wr_q.size(), 32'd0);
    do_job(32'd5, 32'h300, 32'hA00, 16'h0, -1, 1'b0, 10);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
